integral_image_gen: RTL and testbench
=====================================

Name: integral_image_gen

Overview:
- Streaming pre-stage for the per-core face-detection filters. Converts a raster-order stream of 8-bit grey pixels for one core tile into its integral image (summed-area table).
- ii(x,y) = sum of all pixels p(i,j) with i<=x and j<=y. The Haar eye/cheek/nose/mouth box sums downstream use four-corner differences of these values.
- Output is one integral word per input pixel, in the same raster order, ready to be written into the core's image memory.

Parameters:
- MAX_WIDTH, 1024: maximum tile width in pixels; sets the line-buffer depth.
- PIX_W, 8: input pixel width.
- SUM_W, 32: integral word width. Arithmetic is modulo 2^SUM_W.
- DIM_W, 16: width of the dimension and coordinate fields.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame using cfg_width/cfg_height
- cfg_width  in  DIM_W  tile width in pixels (normally 3*size/8)
- cfg_height  in  DIM_W  tile height in pixels
- busy  out  1  high while a frame is in progress
- cfg_err  out  1  one-cycle pulse when start is rejected
- in_valid  in  1  input pixel valid
- in_ready  out  1  input pixel accepted when in_valid && in_ready
- in_pixel  in  PIX_W  pixel value
- out_valid  out  1  output integral word valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  SUM_W  integral value ii(col,row)
- out_addr  out  32  linear address row*width+col, for direct use as the memory index
- out_last  out  1  high with the final word of the frame
- frame_done  out  1  one-cycle pulse after the final word is accepted

Behaviour:
- Reset values: busy=0, cfg_err=0, in_ready=0, out_valid=0, out_data=0, out_addr=0, out_last=0, frame_done=0. Column, row, row_sum and address counters are cleared. Line-buffer contents are don't-care.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - start with 1<=cfg_width<=MAX_WIDTH and cfg_height>=1: latch both dimensions, clear col/row/row_sum/addr, go to RUN, busy=1 from the next cycle.
  - start with any other dimensions: cfg_err=1 for one cycle and stay in IDLE.
  - in_ready=0.
- RUN:
  - in_ready = !out_valid || out_ready. This is a single output register with pass-through on drain.
  - On an accepted pixel:
    - sum_new = row_sum + in_pixel (modulo 2^SUM_W); store it in row_sum.
    - above = (row==0) ? 0 : line_buf[col].
    - Next cycle: out_data = sum_new + above, out_addr = current addr, out_valid=1.
    - out_last=1 iff col==width-1 and row==height-1.
    - line_buf[col] is written with sum_new + above in the same cycle. It is read before the write, so it holds the previous row's value at read time.
  - Latency is exactly 1 cycle from acceptance to out_valid, with no bubble under continuous in_valid/out_ready. Throughput is 1 pixel/clk.
  - Column wrap: at col==width-1, col goes to 0, row_sum goes to 0 and row increments. addr increments on every accepted pixel.
  - At acceptance of the last pixel, go to FLUSH. in_ready drops to 0 from then on.
- FLUSH:
  - Hold out_valid/out_data/out_last until out_ready.
  - On that acceptance: frame_done=1 for one cycle, out_valid=0, busy=0, return to IDLE.
- out_valid, out_data, out_addr and out_last stay stable while out_valid && !out_ready. in_ready is 0 in that condition.
- start while busy is ignored: no cfg_err, and the frame continues.
- Reset at any time, including mid-frame or while out_valid is stalled, returns to IDLE with the reset values above. No partial frame_done is issued.
- A single-pixel frame (1x1) outputs in_pixel and asserts out_last on that word.

Test Plan:
- Basic: start with 3x3, stream nine pixels of 1, out_ready=1 → out_data 1,2,3,2,4,6,3,6,9; out_addr 0..8; out_last only on the 9th word; frame_done 1 cycle after it; busy low afterwards.
- Ramp: 4x2 frame with pixels 1..8 → 1,3,6,10,6,14,24,36.
- Backpressure:
  - Toggle out_ready in the pattern 1,0,0,1 and in_valid randomly on a 3x3 all-ones frame → identical sequence 1,2,3,2,4,6,3,6,9.
  - No word lost or duplicated; data stable while stalled; in_ready=0 whenever out_valid && !out_ready.
- Config errors:
  - cfg_width=0 → cfg_err pulse, busy stays 0.
  - cfg_width=MAX_WIDTH+1 → cfg_err.
  - start during RUN → ignored and the frame completes normally.
- Wrap: SUM_W=12 build, 16x16 frame of 255 (ii(15,15)=65280) → last out_data = 65280 mod 4096 = 3840. Corner-difference of any 2x2 box = 4*255 mod 4096 = 1020.
- Reset mid-frame: assert reset after 5 of 9 pixels → all outputs at reset values, no frame_done. A fresh 3x3 all-ones frame then produces the correct 1..9 pattern, showing no stale row_sum and no stale line-buffer use on row 0.

Source files
------------

// File: rtl/integral_image_gen_if.sv
// Bundle of configuration, pixel-input and integral-output signals for integral_image_gen.
// The master drives configuration, pixels and out_ready. The slave, which is the generator, drives everything else.
interface integral_image_gen_if #(
  parameter int PIX_W = 8,
  parameter int SUM_W = 32,
  parameter int DIM_W = 16
);
  logic             start;
  logic [DIM_W-1:0] cfg_width;
  logic [DIM_W-1:0] cfg_height;
  logic             busy;
  logic             cfg_err;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_data;
  logic [31:0]      out_addr;
  logic             out_last;
  logic             frame_done;

  modport master (
    output start, cfg_width, cfg_height, in_valid, in_pixel, out_ready,
    input  busy, cfg_err, in_ready, out_valid, out_data, out_addr, out_last, frame_done
  );

  modport slave (
    input  start, cfg_width, cfg_height, in_valid, in_pixel, out_ready,
    output busy, cfg_err, in_ready, out_valid, out_data, out_addr, out_last, frame_done
  );
endinterface

// File: rtl/integral_image_gen.sv
// Streaming summed-area table generator: one integral word per raster-order pixel.
// A one-row line buffer holds the previous row's integral values.
module integral_image_gen #(
  parameter int MAX_WIDTH = 1024,
  parameter int PIX_W     = 8,
  parameter int SUM_W     = 32,
  parameter int DIM_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  integral_image_gen_if.slave bus
);

  localparam int IDX_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [DIM_W:0] MAX_W = (DIM_W + 1)'(MAX_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [DIM_W-1:0] width_q, width_d, height_q, height_d;
  logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
  logic [SUM_W-1:0] row_sum_q, row_sum_d;
  logic [31:0]      addr_q, addr_d;
  logic             out_valid_q, out_valid_d;
  logic [SUM_W-1:0] out_data_q, out_data_d;
  logic [31:0]      out_addr_q, out_addr_d;
  logic             out_last_q, out_last_d;
  logic             frame_done_q, frame_done_d;
  logic             cfg_err_q, cfg_err_d;

  logic [SUM_W-1:0] line_buf [MAX_WIDTH];

  logic             in_ready;
  logic             accept;
  logic             cfg_ok;
  logic             last_col;
  logic             last_row;
  logic [IDX_W-1:0] idx;
  logic [SUM_W-1:0] sum_new;
  logic [SUM_W-1:0] above;
  logic [SUM_W-1:0] word;

  // A single output register: a new pixel may enter whenever that register is empty or draining.
  assign in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign accept   = in_ready && bus.in_valid;
  assign cfg_ok   = (bus.cfg_width != '0) && ({1'b0, bus.cfg_width} <= MAX_W) &&
                    (bus.cfg_height != '0);
  assign last_col = (col_q == width_q - DIM_W'(1));
  assign last_row = (row_q == height_q - DIM_W'(1));
  assign idx      = col_q[IDX_W-1:0];
  assign sum_new  = row_sum_q + SUM_W'(bus.in_pixel);
  assign above    = (row_q == '0) ? '0 : line_buf[idx];
  assign word     = sum_new + above;

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    col_d        = col_q;
    row_d        = row_q;
    row_sum_d    = row_sum_q;
    addr_d       = addr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_addr_d   = out_addr_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            width_d   = bus.cfg_width;
            height_d  = bus.cfg_height;
            col_d     = '0;
            row_d     = '0;
            row_sum_d = '0;
            addr_d    = '0;
            state_d   = RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = word;
          out_addr_d  = addr_q;
          out_last_d  = last_col && last_row;
          addr_d      = addr_q + 32'd1;
          if (last_col) begin
            col_d     = '0;
            row_sum_d = '0;
            row_d     = row_q + DIM_W'(1);
            if (last_row) state_d = FLUSH;
          end else begin
            col_d     = col_q + DIM_W'(1);
            row_sum_d = sum_new;
          end
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      FLUSH: begin
        if (bus.out_ready) begin
          out_valid_d  = 1'b0;
          out_last_d   = 1'b0;
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      width_q      <= '0;
      height_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      row_sum_q    <= '0;
      addr_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_addr_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      col_q        <= col_d;
      row_q        <= row_d;
      row_sum_q    <= row_sum_d;
      addr_q       <= addr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_addr_q   <= out_addr_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // Line buffer is unreset storage; the read above sees the previous row before this write lands.
  always_ff @(posedge clk) begin
    if (accept) line_buf[idx] <= word;
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.cfg_err    = cfg_err_q;
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.out_last   = out_last_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_integral_image_gen.sv
// Scoreboard bench for integral_image_gen: expected words are queued when a frame is launched and popped on output handshakes.
// A second instance built with SUM_W=12 exercises modular wrap of the integral.
module tb_integral_image_gen;

  localparam int MAXW = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  integral_image_gen_if #(.PIX_W(8), .SUM_W(32), .DIM_W(16)) bus ();
  integral_image_gen_if #(.PIX_W(8), .SUM_W(12), .DIM_W(16)) wbus ();

  integral_image_gen #(.MAX_WIDTH(MAXW), .PIX_W(8), .SUM_W(32), .DIM_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  integral_image_gen #(.MAX_WIDTH(MAXW), .PIX_W(8), .SUM_W(12), .DIM_W(16)) wdut (
    .clk(clk), .reset(reset), .bus(wbus)
  );

  typedef struct {
    longint data;
    longint addr;
    bit     last;
  } exp_t;

  exp_t   sb[$];
  exp_t   e;
  int     checks = 0;
  int     failures = 0;
  int     doneCount = 0;
  bit     doneExpected = 0;
  bit     stallPrev = 0;
  longint stallData, stallAddr;
  int     rdyMode = 0;
  bit     pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  byte unsigned pix [256];
  longint wArr [256];
  int     wCount = 0;
  longint wLastIdx = -1;

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor for the 32-bit instance, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      stallPrev    = 0;
      doneExpected = 0;
    end else begin
      if (bus.frame_done || doneExpected)
        checkOutput("frame_done", bus.frame_done, doneExpected);
      if (bus.frame_done) begin
        doneCount++;
        checkOutput("busy_at_done", bus.busy, 0);
      end
      doneExpected = 0;
      if (stallPrev) begin
        checkOutput("stall_valid", bus.out_valid, 1);
        checkOutput("stall_data", bus.out_data, stallData);
        checkOutput("stall_addr", bus.out_addr, stallAddr);
      end
      stallPrev = 0;
      if (bus.out_valid) begin
        if (!bus.out_ready) begin
          checkOutput("in_ready_stall", bus.in_ready, 0);
          stallPrev = 1;
          stallData = bus.out_data;
          stallAddr = bus.out_addr;
        end else if (sb.size() == 0) begin
          checkOutput("sb_underflow", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          checkOutput("out_data", bus.out_data, e.data);
          checkOutput("out_addr", bus.out_addr, e.addr);
          checkOutput("out_last", bus.out_last, e.last);
          doneExpected = e.last;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && wbus.out_valid && wbus.out_ready) begin
      wArr[wbus.out_addr[7:0]] = longint'(wbus.out_data);
      wCount++;
      if (wbus.out_last) wLastIdx = wbus.out_addr;
    end
  end

  initial begin
    int i = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rdyMode != 0) begin
        bus.out_ready = pat[i % 4];
        i++;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  task automatic pulseStart(input int w, input int h);
    bus.cfg_width  = 16'(w);
    bus.cfg_height = 16'(h);
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  task automatic sendPixel(input byte unsigned p, input bit randIdle);
    int n = 0;
    bit acc = 0;
    if (randIdle && $urandom_range(0, 2) == 0) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_pixel = p;
    bus.in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) checkOutput("in_ready_timeout", acc, 1);
  endtask

  task automatic waitDone(input int prev);
    int n = 0;
    while (doneCount == prev && n < 200) begin
      tick();
      n++;
    end
    checkOutput("frame_count", doneCount, prev + 1);
    checkOutput("sb_empty", sb.size(), 0);
    checkOutput("busy_after", bus.busy, 0);
  endtask

  // Expected words come straight from the double-sum definition of the integral.
  task automatic pushExpected(input int w, input int h);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        exp_t x;
        longint s = 0;
        for (int j = 0; j <= r; j++)
          for (int k = 0; k <= c; k++)
            s += longint'(pix[j*w + k]);
        x.data = s & 64'hFFFF_FFFF;
        x.addr = r*w + c;
        x.last = (r == h-1) && (c == w-1);
        sb.push_back(x);
      end
    end
  endtask

  task automatic applyStimulus(input int w, input int h, input bit randIdle, input int midStart);
    int prev = doneCount;
    pushExpected(w, h);
    pulseStart(w, h);
    @(negedge clk);
    checkOutput("busy_start", bus.busy, 1);
    checkOutput("cfg_err_ok", bus.cfg_err, 0);
    tick();
    for (int k = 0; k < w*h; k++) begin
      sendPixel(pix[k], randIdle);
      if (k == midStart) begin
        pulseStart(3, 3);
        @(negedge clk);
        checkOutput("start_ignored_err", bus.cfg_err, 0);
        checkOutput("start_ignored_busy", bus.busy, 1);
        tick();
      end
    end
    waitDone(prev);
  endtask

  task automatic cfgErr(input int w, input int h);
    pulseStart(w, h);
    @(negedge clk);
    checkOutput("cfg_err_pulse", bus.cfg_err, 1);
    checkOutput("cfg_err_busy", bus.busy, 0);
    tick();
    @(negedge clk);
    checkOutput("cfg_err_clear", bus.cfg_err, 0);
    tick();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_cfg_err"}, bus.cfg_err, 0);
    checkOutput({tag, "_in_ready"}, bus.in_ready, 0);
    checkOutput({tag, "_out_valid"}, bus.out_valid, 0);
    checkOutput({tag, "_out_data"}, bus.out_data, 0);
    checkOutput({tag, "_out_addr"}, bus.out_addr, 0);
    checkOutput({tag, "_out_last"}, bus.out_last, 0);
    checkOutput({tag, "_frame_done"}, bus.frame_done, 0);
  endtask

  function automatic longint wIi(input int x, input int y);
    if (x < 0 || y < 0) return 0;
    return wArr[y*16 + x];
  endfunction

  function automatic longint wBox(input int x, input int y);
    return (wIi(x, y) - wIi(x-2, y) - wIi(x, y-2) + wIi(x-2, y-2)) & 64'hFFF;
  endfunction

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int prev;
    int n;
    int wCycles;
    bit acc;
    reset = 1'b1;
    bus.start = 1'b0; bus.cfg_width = '0; bus.cfg_height = '0;
    bus.in_valid = 1'b0; bus.in_pixel = '0;
    wbus.start = 1'b0; wbus.cfg_width = '0; wbus.cfg_height = '0;
    wbus.in_valid = 1'b0; wbus.in_pixel = '0; wbus.out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checkResetValues("reset");
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] basic 3x3 all ones");
    for (int k = 0; k < 9; k++) pix[k] = 8'd1;
    applyStimulus(3, 3, 0, -1);

    $display("[TB] ramp 4x2 with ignored start mid-frame");
    for (int k = 0; k < 8; k++) pix[k] = 8'(k + 1);
    applyStimulus(4, 2, 0, 2);

    $display("[TB] single pixel frame");
    pix[0] = 8'd77;
    applyStimulus(1, 1, 0, -1);

    $display("[TB] random 5x4 frame with idle gaps");
    for (int k = 0; k < 20; k++) pix[k] = 8'($urandom_range(0, 255));
    applyStimulus(5, 4, 1, -1);

    $display("[TB] configuration errors");
    cfgErr(0, 3);
    cfgErr(MAXW + 1, 3);
    cfgErr(3, 0);

    $display("[TB] backpressure 3x3 all ones");
    for (int k = 0; k < 9; k++) pix[k] = 8'd1;
    rdyMode = 1;
    applyStimulus(3, 3, 1, -1);
    rdyMode = 0;
    tick();

    $display("[TB] reset mid-frame");
    prev = doneCount;
    pushExpected(3, 3);
    pulseStart(3, 3);
    tick();
    for (int k = 0; k < 5; k++) sendPixel(8'd1, 0);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    checkResetValues("midrst");
    tick();
    reset = 1'b0;
    repeat (10) tick();
    checkOutput("no_done_after_reset", doneCount, prev);
    applyStimulus(3, 3, 0, -1);

    $display("[TB] 12-bit wrap 16x16 of 255");
    wbus.cfg_width = 16'd16;
    wbus.cfg_height = 16'd16;
    wbus.start = 1'b1;
    tick();
    wbus.start = 1'b0;
    wCycles = 0;
    for (int k = 0; k < 256; k++) begin
      wbus.in_pixel = 8'd255;
      wbus.in_valid = 1'b1;
      acc = 0;
      n = 0;
      while (!acc && n < 200) begin
        @(negedge clk);
        acc = wbus.in_ready;
        tick();
        n++;
      end
      wCycles += n;
      if (!acc) checkOutput("wrap_in_timeout", acc, 1);
    end
    wbus.in_valid = 1'b0;
    n = 0;
    while (wCount < 256 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("wrap_count", wCount, 256);
    checkOutput("wrap_throughput", wCycles, 256);
    checkOutput("wrap_last_addr", wLastIdx, 255);
    checkOutput("wrap_last_data", wArr[255], 3840);
    checkOutput("wrap_box_1_1", wBox(1, 1), 1020);
    checkOutput("wrap_box_7_4", wBox(7, 4), 1020);
    checkOutput("wrap_box_10_12", wBox(10, 12), 1020);
    checkOutput("wrap_box_15_15", wBox(15, 15), 1020);
    tick();
    checkOutput("wrap_busy_after", wbus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
